// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART core.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
  } rx_state_e;

  localparam int unsigned MIN_CLKS_PER_BIT = 8;

  function automatic int unsigned clks_per_bit(input int unsigned clk, input int unsigned baud);
    return clk / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, 3-sample majority vote, framing/parity checks.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CPB       = 16,
  parameter int unsigned DATA_BITS = 8,
  parameter parity_e     PAR_MODE  = PAR_NONE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);
  localparam int unsigned HALF = CPB / 2;
  localparam int unsigned CW   = $clog2(CPB);
  localparam int unsigned BW   = $clog2(DATA_BITS);

  rx_state_e            r_state, w_state_nxt;
  logic                 r_meta, r_sync, r_sync_d;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shreg, r_data;
  logic                 r_s0, r_s1, r_par_bad, r_valid, r_ferr, r_perr;
  logic                 w_start, w_decide, w_bit_end, w_last, w_maj;
  logic                 w_shift_en, w_par_en, w_done;

  assign w_start   = r_sync_d & ~r_sync;
  assign w_decide  = (r_cnt == CW'(HALF + 1));
  assign w_bit_end = (r_cnt == CW'(CPB - 1));
  assign w_last    = (r_bit == BW'(DATA_BITS - 1));
  // third sample is the live synchronised value at offset HALF+1
  assign w_maj     = (r_s0 & r_s1) | (r_s0 & r_sync) | (r_s1 & r_sync);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RX_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RX_IDLE:      if (w_start) w_state_nxt = RX_START;
      RX_START:     if (w_decide && w_maj) w_state_nxt = RX_IDLE;
                    else if (w_bit_end)    w_state_nxt = RX_DATA;
      RX_DATA:      if (w_bit_end && w_last)
                      w_state_nxt = (PAR_MODE == PAR_NONE) ? RX_STOP : RX_PARITY;
      RX_PARITY:    if (w_bit_end) w_state_nxt = RX_STOP;
      RX_STOP:      if (w_decide) w_state_nxt = w_maj ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (r_sync) w_state_nxt = RX_IDLE;
      default:      w_state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    w_shift_en = (r_state == RX_DATA)   && w_decide;
    w_par_en   = (r_state == RX_PARITY) && w_decide;
    w_done     = (r_state == RX_STOP)   && w_decide;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta    <= 1'b1;
      r_sync    <= 1'b1;
      r_sync_d  <= 1'b1;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shreg   <= '0;
      r_s0      <= 1'b0;
      r_s1      <= 1'b0;
      r_par_bad <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_ferr    <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_meta   <= rx;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
      // the falling-edge cycle is offset 0, so counting resumes at 1
      if (r_state == RX_IDLE)                     r_cnt <= {{(CW-1){1'b0}}, w_start};
      else if (r_state == RX_WAIT_HIGH || w_bit_end) r_cnt <= '0;
      else                                        r_cnt <= r_cnt + CW'(1);
      if (r_state != RX_DATA) r_bit <= '0;
      else if (w_bit_end)     r_bit <= r_bit + BW'(1);
      if (r_cnt == CW'(HALF - 1)) r_s0 <= r_sync;
      if (r_cnt == CW'(HALF))     r_s1 <= r_sync;
      if (w_shift_en) r_shreg <= {w_maj, r_shreg[DATA_BITS-1:1]};
      if (r_state == RX_IDLE) r_par_bad <= 1'b0;
      else if (w_par_en)      r_par_bad <= w_maj ^ (^r_shreg) ^ (PAR_MODE == PAR_ODD);
      r_valid <= w_done;
      if (w_done) begin
        r_data <= r_shreg;
        r_ferr <= ~w_maj;
        r_perr <= r_par_bad;
      end
    end
  end

  assign rx_data       = r_data;
  assign rx_valid      = r_valid;
  assign rx_frame_err  = r_ferr;
  assign rx_parity_err = r_perr;

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: inline TX FSM with valid/ready handshake, receiver in uart_rx.
module uart_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);
  localparam int unsigned CPB      = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned STOP_LEN = STOP_BITS * CPB;
  localparam int unsigned CW       = $clog2(2 * CPB);
  localparam int unsigned BW       = $clog2(DATA_BITS);
  localparam parity_e     PAR_MODE = parity_e'(PARITY[1:0]);

  if (CPB < MIN_CLKS_PER_BIT || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
    $fatal(1, "uart_core: illegal parameter set");
  end

  tx_state_e            r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 r_par, r_tx;
  logic                 w_bit_end, w_stop_end, w_last, w_hs, w_tx_nxt;

  assign w_bit_end  = (r_cnt == CW'(CPB - 1));
  assign w_stop_end = (r_cnt == CW'(STOP_LEN - 1));
  assign w_last     = (r_bit == BW'(DATA_BITS - 1));
  // ready also on the final stop cycle so a held tx_valid runs frames back to back
  assign tx_ready   = (r_state == TX_IDLE) || (r_state == TX_STOP && w_stop_end);
  assign w_hs       = tx_valid && tx_ready;
  assign tx         = r_tx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= TX_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      TX_IDLE:   if (w_hs) w_state_nxt = TX_START;
      TX_START:  if (w_bit_end) w_state_nxt = TX_DATA;
      TX_DATA:   if (w_bit_end && w_last)
                   w_state_nxt = (PAR_MODE == PAR_NONE) ? TX_STOP : TX_PARITY;
      TX_PARITY: if (w_bit_end) w_state_nxt = TX_STOP;
      TX_STOP:   if (w_stop_end) w_state_nxt = w_hs ? TX_START : TX_IDLE;
      default:   w_state_nxt = TX_IDLE;
    endcase
  end

  // tx is registered from the next state so the pin never glitches
  always_comb begin
    w_tx_nxt = 1'b1;
    unique case (w_state_nxt)
      TX_START:  w_tx_nxt = 1'b0;
      TX_DATA:   w_tx_nxt = (r_state == TX_DATA && w_bit_end) ? r_shreg[1] : r_shreg[0];
      TX_PARITY: w_tx_nxt = r_par;
      default:   w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_tx <= w_tx_nxt;
      if (w_hs) begin
        r_shreg <= tx_data;
        r_par   <= (^tx_data) ^ (PAR_MODE == PAR_ODD);
      end else if (r_state == TX_DATA && w_bit_end) begin
        r_shreg <= r_shreg >> 1;
      end
      if (r_state == TX_IDLE || w_state_nxt != r_state || (w_bit_end && r_state != TX_STOP))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CW'(1);
      if (r_state != TX_DATA) r_bit <= '0;
      else if (w_bit_end)     r_bit <= r_bit + BW'(1);
    end
  end

  uart_rx #(
    .CPB       (CPB),
    .DATA_BITS (DATA_BITS),
    .PAR_MODE  (PAR_MODE)
  ) u_rx (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err)
  );

endmodule

// File: tb/tb_uart_core.sv
// Directed bench: 8N1 (A), 8E1 loopback (B) and 7O2 (C) instances at 16 clocks per bit.
module tb_uart_core;
  localparam int unsigned CF = 1_600_000;
  localparam int unsigned BD = 100_000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] a_tx_data = '0;
  logic       a_tx_valid = 1'b0, a_rx = 1'b1;
  logic       a_tx_ready, a_tx, a_rx_valid, a_ferr, a_perr;
  logic [7:0] a_rx_data;

  logic [7:0] b_tx_data = '0;
  logic       b_tx_valid = 1'b0;
  logic       b_tx_ready, b_line, b_rx_valid, b_ferr, b_perr;
  logic [7:0] b_rx_data;

  logic [6:0] c_tx_data = '0;
  logic       c_tx_valid = 1'b0, c_rx = 1'b1;
  logic       c_tx_ready, c_tx, c_rx_valid, c_ferr, c_perr;
  logic [6:0] c_rx_data;

  uart_core #(.CLK_FREQ(CF), .BAUD(BD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .tx(a_tx), .rx(a_rx), .rx_data(a_rx_data), .rx_valid(a_rx_valid),
    .rx_frame_err(a_ferr), .rx_parity_err(a_perr));

  uart_core #(.CLK_FREQ(CF), .BAUD(BD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_b (
    .clk(clk), .rst_n(rst_n), .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .tx(b_line), .rx(b_line), .rx_data(b_rx_data), .rx_valid(b_rx_valid),
    .rx_frame_err(b_ferr), .rx_parity_err(b_perr));

  uart_core #(.CLK_FREQ(CF), .BAUD(BD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_c (
    .clk(clk), .rst_n(rst_n), .tx_data(c_tx_data), .tx_valid(c_tx_valid), .tx_ready(c_tx_ready),
    .tx(c_tx), .rx(c_rx), .rx_data(c_rx_data), .rx_valid(c_rx_valid),
    .rx_frame_err(c_ferr), .rx_parity_err(c_perr));

  int unsigned cyc = 0, a_cnt = 0, b_cnt = 0, c_cnt = 0;
  logic [7:0]  a_last = '0;
  logic        a_last_ferr = 1'b0, a_last_perr = 1'b0;
  logic [6:0]  c_last = '0;
  logic        c_last_ferr = 1'b0, c_last_perr = 1'b0;
  logic [7:0]  b_data [4];
  int unsigned b_cyc  [4];
  logic        b_err  [4];

  // receive-side event log, captured mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (a_rx_valid) begin
      a_cnt++; a_last = a_rx_data; a_last_ferr = a_ferr; a_last_perr = a_perr;
    end
    if (c_rx_valid) begin
      c_cnt++; c_last = c_rx_data; c_last_ferr = c_ferr; c_last_perr = c_perr;
    end
    if (b_rx_valid) begin
      if (b_cnt < 4) begin
        b_data[b_cnt] = b_rx_data; b_cyc[b_cnt] = cyc; b_err[b_cnt] = b_ferr | b_perr;
      end
      b_cnt++;
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int unsigned which, input logic v);
    if (which == 0) a_rx = v;
    else            c_rx = v;
  endtask

  task automatic drive_bits(input int unsigned which, input logic [15:0] bits, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      set_rx(which, bits[i]);
      tick(16);
    end
    set_rx(which, 1'b1);
  endtask

  task automatic send_tx_a(input logic [7:0] d);
    logic [9:0] frame;
    frame = {1'b1, d, 1'b0};
    chk("tx_ready_before", a_tx_ready, 1);
    a_tx_data  = d;
    a_tx_valid = 1'b1;
    tick(1);
    a_tx_valid = 1'b0;
    for (int unsigned k = 1; k <= 160; k++) begin
      chk("tx_bit", a_tx, frame[(k-1)/16]);
      chk("tx_ready_frame", a_tx_ready, (k == 160));
      tick(1);
    end
    chk("tx_idle_after", a_tx, 1);
    chk("tx_ready_after", a_tx_ready, 1);
  endtask

  int unsigned base;

  initial begin
    #2 rst_n = 1'b0;
    tick(3);
    chk("rst_a_tx", a_tx, 1);
    chk("rst_a_ready", a_tx_ready, 1);
    chk("rst_a_valid", a_rx_valid, 0);
    chk("rst_a_data", a_rx_data, 0);
    chk("rst_a_ferr", a_ferr, 0);
    chk("rst_a_perr", a_perr, 0);
    chk("rst_b_tx", b_line, 1);
    chk("rst_c_ready", c_tx_ready, 1);
    rst_n = 1'b1;
    tick(2);

    // 8N1 transmit of 0xA5
    send_tx_a(8'hA5);

    // 8E1 loopback, tx_valid held across three frames
    b_tx_valid = 1'b1;
    b_tx_data  = 8'h00;
    for (int i = 0; i < 3; i++) begin
      for (int w = 0; w < 400 && !b_tx_ready; w++) tick(1);
      chk("lb_ready", b_tx_ready, 1);
      tick(1);
      b_tx_data = (i == 0) ? 8'hFF : 8'h3C;
    end
    b_tx_valid = 1'b0;
    for (int w = 0; w < 600 && b_cnt < 3; w++) tick(1);
    tick(20);
    chk("lb_count", b_cnt, 3);
    chk("lb_data0", b_data[0], 8'h00);
    chk("lb_data1", b_data[1], 8'hFF);
    chk("lb_data2", b_data[2], 8'h3C);
    chk("lb_gap01", b_cyc[1] - b_cyc[0], 176);
    chk("lb_gap12", b_cyc[2] - b_cyc[1], 176);
    chk("lb_err0", b_err[0], 0);
    chk("lb_err1", b_err[1], 0);
    chk("lb_err2", b_err[2], 0);

    // 7O2 receive of 0x55 with parity bit 0 (odd parity needs 1)
    base = c_cnt;
    drive_bits(1, {2'b11, 1'b0, 7'h55, 1'b0}, 11);
    tick(4);
    chk("par_count", c_cnt, base + 1);
    chk("par_data", c_last, 7'h55);
    chk("par_perr", c_last_perr, 1);
    chk("par_ferr", c_last_ferr, 0);

    // 4-cycle glitch is a false start; following 0x81 frame is received
    base = a_cnt;
    a_rx = 1'b0;
    tick(4);
    a_rx = 1'b1;
    tick(20);
    chk("glitch_none", a_cnt, base);
    drive_bits(0, {1'b1, 8'h81, 1'b0}, 10);
    tick(4);
    chk("glitch_count", a_cnt, base + 1);
    chk("glitch_data", a_last, 8'h81);
    chk("glitch_ferr", a_last_ferr, 0);
    chk("glitch_perr", a_last_perr, 0);

    // break: 400 low cycles give exactly one framing-error pulse
    base = a_cnt;
    a_rx = 1'b0;
    tick(400);
    chk("break_count", a_cnt, base + 1);
    chk("break_ferr", a_last_ferr, 1);
    chk("break_data", a_last, 8'h00);
    a_rx = 1'b1;
    tick(40);
    chk("break_quiet", a_cnt, base + 1);
    drive_bits(0, {1'b1, 8'h5A, 1'b0}, 10);
    tick(4);
    chk("break_next_count", a_cnt, base + 2);
    chk("break_next_data", a_last, 8'h5A);
    chk("break_next_ferr", a_last_ferr, 0);

    // reset in the middle of a TX frame (0xC3, data bit 2 = 0) and an RX frame
    base = a_cnt;
    a_tx_data  = 8'hC3;
    a_tx_valid = 1'b1;
    tick(1);
    a_tx_valid = 1'b0;
    a_rx = 1'b0;
    tick(50);
    chk("mid_tx_low", a_tx, 0);
    chk("mid_ready_low", a_tx_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx", a_tx, 1);
    chk("async_rst_ready", a_tx_ready, 1);
    chk("async_rst_valid", a_rx_valid, 0);
    a_rx = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    chk("rst_no_valid", a_cnt, base);
    send_tx_a(8'h3C);
    drive_bits(0, {1'b1, 8'h3C, 1'b0}, 10);
    tick(4);
    chk("post_rst_count", a_cnt, base + 1);
    chk("post_rst_data", a_last, 8'h3C);
    chk("post_rst_ferr", a_last_ferr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
